// File: rtl/exec_issue_ctrl.sv
// rtl/exec_issue_ctrl.sv - issue/writeback scheduler for exec1 ALU and M1..M5 multiply pipe
module exec_issue_ctrl #(
  parameter int MUL_LAT  = 5,
  parameter int REG_ADDR = 5,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                dec_valid,
  input  logic                dec_is_mult,
  input  logic                dec_regwrite,
  input  logic [REG_ADDR-1:0] dec_wreg,
  input  logic                dec_use1,
  input  logic                dec_use2,
  input  logic [REG_ADDR-1:0] dec_rs1,
  input  logic [REG_ADDR-1:0] dec_rs2,
  output logic                dec_ready,
  output logic                regwrite_in,
  output logic                regwrite_mult_in,
  output logic                issue_alu,
  output logic                issue_mult,
  output logic                wb_en,
  output logic                wb_sel,
  output logic [REG_ADDR-1:0] wb_reg,
  output logic                wb_conflict,
  output logic [CNT_W-1:0]    stall_cnt
);

  // sb_*[0] is the multiply result being written back this cycle
  logic [MUL_LAT-1:0]  sb_v;
  logic [REG_ADDR-1:0] sb_reg [MUL_LAT];
  logic                ap_v;
  logic [REG_ADDR-1:0] ap_reg;

  logic raw1, raw2, waw, collide, stall;

  always_comb begin
    raw1 = dec_use1 && (dec_rs1 != '0) && ap_v && (ap_reg == dec_rs1);
    raw2 = dec_use2 && (dec_rs2 != '0) && ap_v && (ap_reg == dec_rs2);
    waw  = 1'b0;
    for (int k = 0; k < MUL_LAT; k++) begin
      if (sb_v[k] && dec_use1 && (dec_rs1 != '0) && (sb_reg[k] == dec_rs1)) raw1 = 1'b1;
      if (sb_v[k] && dec_use2 && (dec_rs2 != '0) && (sb_reg[k] == dec_rs2)) raw2 = 1'b1;
      if (sb_v[k] && dec_regwrite && (dec_wreg != '0) && (sb_reg[k] == dec_wreg)) waw = 1'b1;
    end
    // an ALU result now would land on the same cycle as the mult in sb[1]
    collide = !dec_is_mult && dec_regwrite && sb_v[1];
    stall   = dec_valid && (raw1 || raw2 || waw || collide);
  end

  assign dec_ready        = !stall && !reset;
  assign issue_alu        = dec_valid && !stall && !dec_is_mult && !reset;
  assign issue_mult       = dec_valid && !stall && dec_is_mult && !reset;
  assign regwrite_in      = issue_alu && dec_regwrite;
  assign regwrite_mult_in = issue_mult && dec_regwrite;

  always_comb begin
    wb_en  = 1'b0;
    wb_sel = 1'b0;
    wb_reg = '0;
    if (!reset) begin
      if (sb_v[0]) begin
        wb_en  = 1'b1;
        wb_sel = 1'b1;
        wb_reg = sb_reg[0];
      end else if (ap_v) begin
        wb_en  = 1'b1;
        wb_reg = ap_reg;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sb_v        <= '0;
      for (int i = 0; i < MUL_LAT; i++) sb_reg[i] <= '0;
      ap_v        <= 1'b0;
      ap_reg      <= '0;
      wb_conflict <= 1'b0;
      stall_cnt   <= '0;
    end else begin
      for (int i = 0; i < MUL_LAT - 1; i++) begin
        sb_v[i]   <= sb_v[i+1];
        sb_reg[i] <= sb_reg[i+1];
      end
      sb_v[MUL_LAT-1]   <= regwrite_mult_in && (dec_wreg != '0);
      sb_reg[MUL_LAT-1] <= dec_wreg;
      ap_v              <= regwrite_in && (dec_wreg != '0);
      ap_reg            <= dec_wreg;
      if (sb_v[0] && ap_v) wb_conflict <= 1'b1;
      if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_exec_issue_ctrl.sv
// tb/tb_exec_issue_ctrl.sv - directed and randomized checks for exec_issue_ctrl
module tb_exec_issue_ctrl;

  logic        clk, reset;
  logic        dec_valid, dec_is_mult, dec_regwrite, dec_use1, dec_use2;
  logic [4:0]  dec_wreg, dec_rs1, dec_rs2;
  logic        dec_ready, regwrite_in, regwrite_mult_in, issue_alu, issue_mult;
  logic        wb_en, wb_sel, wb_conflict;
  logic [4:0]  wb_reg;
  logic [15:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  logic        s_ready, s_ia, s_im, s_rwi, s_rwm, s_wben, s_wbsel, s_conf;
  logic [4:0]  s_wbreg;
  logic [15:0] s_cnt;

  typedef struct {
    logic [4:0] r;
    int         wb;
    bit         m;
  } pend_t;
  pend_t pq[$];

  exec_issue_ctrl #(.MUL_LAT(5), .REG_ADDR(5), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .dec_valid(dec_valid), .dec_is_mult(dec_is_mult), .dec_regwrite(dec_regwrite),
    .dec_wreg(dec_wreg), .dec_use1(dec_use1), .dec_use2(dec_use2),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_ready(dec_ready),
    .regwrite_in(regwrite_in), .regwrite_mult_in(regwrite_mult_in),
    .issue_alu(issue_alu), .issue_mult(issue_mult),
    .wb_en(wb_en), .wb_sel(wb_sel), .wb_reg(wb_reg),
    .wb_conflict(wb_conflict), .stall_cnt(stall_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic sample;
    s_ready = dec_ready; s_ia = issue_alu; s_im = issue_mult;
    s_rwi = regwrite_in; s_rwm = regwrite_mult_in;
    s_wben = wb_en; s_wbsel = wb_sel; s_wbreg = wb_reg;
    s_conf = wb_conflict; s_cnt = stall_cnt;
  endtask

  // one cycle: drive just after posedge, sample at negedge, return just after next posedge
  task automatic drive(input logic v, input logic m, input logic rw, input logic [4:0] wr,
                       input logic u1, input logic [4:0] r1, input logic u2, input logic [4:0] r2);
    dec_valid = v; dec_is_mult = m; dec_regwrite = rw; dec_wreg = wr;
    dec_use1 = u1; dec_rs1 = r1; dec_use2 = u2; dec_rs2 = r2;
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    drive(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
  endtask

  task automatic do_reset;
    reset = 1'b1;
    dec_valid = 1'b0; dec_is_mult = 1'b0; dec_regwrite = 1'b0; dec_wreg = '0;
    dec_use1 = 1'b0; dec_rs1 = '0; dec_use2 = 1'b0; dec_rs2 = '0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    dec_valid = 1'b1; dec_is_mult = 1'b0; dec_regwrite = 1'b1; dec_wreg = 5'd3;
    dec_use1 = 1'b0; dec_rs1 = '0; dec_use2 = 1'b0; dec_rs2 = '0;
    @(negedge clk);
    sample();
    checks++;
    if ({s_ready, s_ia, s_im, s_rwi, s_wben, s_conf} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs got=%b want=000000", {s_ready, s_ia, s_im, s_rwi, s_wben, s_conf});
    end
    checks++;
    if (s_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_stall_cnt got=%0d want=0", s_cnt);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle();
    checks++;
    if (s_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_first_ready got=%b want=1", s_ready);
    end
  endtask

  task automatic test_alu;
    do_reset();
    drive(1'b1, 1'b0, 1'b1, 5'd3, 1'b0, 5'd0, 1'b0, 5'd0);
    checks++;
    if ({s_ia, s_rwi, s_im, s_rwm} !== 4'b1100) begin
      errors++;
      $display("FAIL alu_issue got=%b want=1100", {s_ia, s_rwi, s_im, s_rwm});
    end
    idle();
    checks++;
    if ({s_wben, s_wbsel, s_wbreg} !== {1'b1, 1'b0, 5'd3}) begin
      errors++;
      $display("FAIL alu_wb got=%b/%b/%0d want=1/0/3", s_wben, s_wbsel, s_wbreg);
    end
    idle();
    checks++;
    if (s_wben !== 1'b0) begin
      errors++;
      $display("FAIL alu_wb_once got=%b want=0", s_wben);
    end
  endtask

  task automatic test_raw_mult;
    do_reset();
    drive(1'b1, 1'b1, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 5'd0);
    checks++;
    if ({s_im, s_rwm, s_ia} !== 3'b110) begin
      errors++;
      $display("FAIL raw_mult_issue got=%b want=110", {s_im, s_rwm, s_ia});
    end
    for (int c = 1; c <= 6; c++) begin
      drive(1'b1, 1'b0, 1'b1, 5'd9, 1'b1, 5'd5, 1'b0, 5'd0);
      checks++;
      if (s_ready !== (c == 6)) begin
        errors++;
        $display("FAIL raw_ready_c%0d got=%b want=%b", c, s_ready, (c == 6));
      end
      if (c == 5) begin
        checks++;
        if ({s_wben, s_wbsel, s_wbreg} !== {1'b1, 1'b1, 5'd5}) begin
          errors++;
          $display("FAIL raw_mult_wb got=%b/%b/%0d want=1/1/5", s_wben, s_wbsel, s_wbreg);
        end
      end
    end
    idle();
    checks++;
    if ({s_wben, s_wbsel, s_wbreg} !== {1'b1, 1'b0, 5'd9}) begin
      errors++;
      $display("FAIL raw_alu_wb got=%b/%b/%0d want=1/0/9", s_wben, s_wbsel, s_wbreg);
    end
    checks++;
    if (s_cnt !== 16'd5) begin
      errors++;
      $display("FAIL raw_stall_cnt got=%0d want=5", s_cnt);
    end
  endtask

  task automatic test_collision;
    do_reset();
    drive(1'b1, 1'b1, 1'b1, 5'd4, 1'b0, 5'd0, 1'b0, 5'd0);
    for (int c = 1; c <= 3; c++) idle();
    drive(1'b1, 1'b0, 1'b1, 5'd7, 1'b0, 5'd0, 1'b0, 5'd0);
    checks++;
    if ({s_ready, s_ia} !== 2'b00) begin
      errors++;
      $display("FAIL coll_stall_c4 got=%b want=00", {s_ready, s_ia});
    end
    drive(1'b1, 1'b0, 1'b1, 5'd7, 1'b0, 5'd0, 1'b0, 5'd0);
    checks++;
    if ({s_ia, s_wben, s_wbsel, s_wbreg} !== {1'b1, 1'b1, 1'b1, 5'd4}) begin
      errors++;
      $display("FAIL coll_c5 got=%b/%b/%b/%0d want=1/1/1/4", s_ia, s_wben, s_wbsel, s_wbreg);
    end
    idle();
    checks++;
    if ({s_wben, s_wbsel, s_wbreg, s_conf} !== {1'b1, 1'b0, 5'd7, 1'b0}) begin
      errors++;
      $display("FAIL coll_c6 got=%b/%b/%0d/%b want=1/0/7/0", s_wben, s_wbsel, s_wbreg, s_conf);
    end
  endtask

  task automatic test_waw;
    int issued_at;
    issued_at = -1;
    do_reset();
    drive(1'b1, 1'b1, 1'b1, 5'd6, 1'b0, 5'd0, 1'b0, 5'd0);
    for (int c = 1; c <= 20 && issued_at < 0; c++) begin
      drive(1'b1, 1'b0, 1'b1, 5'd6, 1'b0, 5'd0, 1'b0, 5'd0);
      if (s_ia === 1'b1) issued_at = c;
    end
    idle();
    checks++;
    if (issued_at != 6) begin
      errors++;
      $display("FAIL waw_issue_cycle got=%0d want=6", issued_at);
    end
  endtask

  task automatic test_back_to_back;
    do_reset();
    for (int c = 0; c < 5; c++) begin
      drive(1'b1, 1'b1, 1'b1, 5'(c + 1), 1'b0, 5'd0, 1'b0, 5'd0);
      checks++;
      if ({s_ready, s_im} !== 2'b11) begin
        errors++;
        $display("FAIL b2b_issue_c%0d got=%b want=11", c, {s_ready, s_im});
      end
    end
    for (int c = 5; c < 10; c++) begin
      idle();
      checks++;
      if ({s_wben, s_wbsel, s_wbreg} !== {1'b1, 1'b1, 5'(c - 4)}) begin
        errors++;
        $display("FAIL b2b_wb_c%0d got=%b/%b/%0d want=1/1/%0d", c, s_wben, s_wbsel, s_wbreg, c - 4);
      end
    end
  endtask

  task automatic test_reset_mid;
    do_reset();
    drive(1'b1, 1'b1, 1'b1, 5'd8, 1'b0, 5'd0, 1'b0, 5'd0);
    drive(1'b1, 1'b0, 1'b1, 5'd2, 1'b0, 5'd0, 1'b0, 5'd0);
    dec_valid = 1'b1; dec_is_mult = 1'b1; dec_regwrite = 1'b1; dec_wreg = 5'd9;
    #2;
    reset = 1'b1;
    #1;
    sample();
    checks++;
    if ({s_ready, s_im, s_rwm, s_wben} !== 4'b0000) begin
      errors++;
      $display("FAIL midreset_outputs got=%b want=0000", {s_ready, s_im, s_rwm, s_wben});
    end
    #1;
    reset = 1'b0;
    dec_valid = 1'b0;
    @(posedge clk);
    #1;
    for (int c = 3; c <= 8; c++) begin
      idle();
      checks++;
      if (s_wben !== 1'b0) begin
        errors++;
        $display("FAIL midreset_wb_c%0d got=%b want=0", c, s_wben);
      end
    end
  endtask

  task automatic test_random;
    int          cyc;
    int          exp_cnt;
    logic        v, m, rw, u1, u2;
    logic [4:0]  wr, r1, r2;
    bit          raw, waw, col, stl, held;
    logic [11:0] exp_vec, got_vec;
    logic        e_en, e_sel;
    logic [4:0]  e_reg;
    do_reset();
    pq.delete();
    cyc = 0; exp_cnt = 0; held = 0;
    v = 0; m = 0; rw = 0; u1 = 0; u2 = 0; wr = 0; r1 = 0; r2 = 0;
    for (int n = 0; n < 10000; n++) begin
      if (!held) begin
        v  = ($urandom_range(0, 9) < 8);
        m  = ($urandom_range(0, 2) == 0);
        rw = ($urandom_range(0, 4) != 0);
        wr = 5'($urandom_range(0, 7));
        u1 = $urandom_range(0, 1) == 1; r1 = 5'($urandom_range(0, 7));
        u2 = $urandom_range(0, 1) == 1; r2 = 5'($urandom_range(0, 7));
      end
      raw = 0; waw = 0; col = 0;
      e_en = 0; e_sel = 0; e_reg = 0;
      foreach (pq[i]) begin
        if (u1 && r1 != 0 && pq[i].r == r1) raw = 1;
        if (u2 && r2 != 0 && pq[i].r == r2) raw = 1;
        if (pq[i].m && rw && wr != 0 && pq[i].r == wr) waw = 1;
        if (pq[i].m && pq[i].wb == cyc + 1 && !m && rw) col = 1;
        if (pq[i].wb == cyc && (pq[i].m || !e_en)) begin
          e_en = 1; e_sel = pq[i].m; e_reg = pq[i].r;
        end
      end
      stl = v && (raw || waw || col);
      exp_vec = {!stl, v && !stl && !m, v && !stl && m, v && !stl && !m && rw,
                 v && !stl && m && rw, e_en, e_sel, e_reg};
      drive(v, m, rw, wr, u1, r1, u2, r2);
      got_vec = {s_ready, s_ia, s_im, s_rwi, s_rwm, s_wben, s_wbsel, s_wbreg};
      checks++;
      if (got_vec !== exp_vec) begin
        errors++;
        $display("FAIL rand_cyc%0d got=%b want=%b", cyc, got_vec, exp_vec);
      end
      if (stl && exp_cnt < 65535) exp_cnt++;
      if (v && !stl && rw && wr != 0) pq.push_back('{r: wr, wb: cyc + (m ? 5 : 1), m: m});
      held = stl && ($urandom_range(0, 3) != 0);
      cyc++;
      for (int i = pq.size() - 1; i >= 0; i--) if (pq[i].wb < cyc) pq.delete(i);
    end
    idle();
    checks++;
    if (s_conf !== 1'b0) begin
      errors++;
      $display("FAIL rand_wb_conflict got=%b want=0", s_conf);
    end
    checks++;
    if (s_cnt !== 16'(exp_cnt)) begin
      errors++;
      $display("FAIL rand_stall_cnt got=%0d want=%0d", s_cnt, exp_cnt);
    end
  endtask

  initial begin
    reset = 1'b1;
    dec_valid = 1'b0; dec_is_mult = 1'b0; dec_regwrite = 1'b0; dec_wreg = '0;
    dec_use1 = 1'b0; dec_rs1 = '0; dec_use2 = 1'b0; dec_rs2 = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_alu();
    test_raw_mult();
    test_collision();
    test_waw();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
